pwm_shadow_register_file: RTL
=============================

# pwm_shadow_register_file

Parametrised, double-buffered configuration register file for the PWM peripheral, sitting between the byte-wide host bus (SPI/parallel front end) and CHANNELS PWM channel cores. Each channel owns a 16-byte window. Writes land in a shadow bank and are committed to the active bank atomically at that channel's period boundary, or on a forced commit. Active values drive the PWM cores, so period and compare changes never tear mid-cycle. A per-channel status register and an optional write-lock are included.

## Interface
Parameters:
- CHANNELS, 3, number of PWM channels (1..8)
- ADDRESS_WIDTH, 6, host address width; must satisfy 2^ADDRESS_WIDTH >= CHANNELS*16+2

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high; clock i_clk
- i_write_en  in  1  write strobe, one write per cycle high
- i_address  in  ADDRESS_WIDTH  register address
- i_data  in  8  write data
- o_data  out  8  combinational read data for i_address
- i_period_end  in  CHANNELS  per-channel one-cycle pulse from the period counter at counter wrap
- o_active_regs  out  CHANNELS*15*8  active registers; channel c offset k at bits [(c*15+k)*8 +: 8]
- o_write_error  out  1  one-cycle pulse when a write is rejected

## Operation
- Map: channel c base = c*16. Offsets 0x0..0xE: control, period msb/lsb, A action, A compa msb/lsb, A compb msb/lsb, A deadband, B action, B compa msb/lsb, B compb msb/lsb, B deadband. Offset 0xF: status. GLOBAL = CHANNELS*16 (commit register). KEY = GLOBAL+1 (lock, macro only). Any other address is unmapped.
- Control bit7 = SHDW (shadow enable). The control register (offset 0) is always written to shadow and active in the same cycle.
- Offsets 0x1..0xE with active SHDW=0: write goes to shadow and active together.
- Offsets 0x1..0xE with active SHDW=1: write goes to shadow only and sets pending[c].
- Commit[c] = i_period_end[c] OR a forced commit. On commit, active <= shadow for offsets 1..14. The pending flag clears, and sticky updated[c] is set only if pending was 1.
- Status byte: bit0 = pending, bit1 = updated (sticky), bits7..2 = 0. Writing 1 to bit1 clears updated. Other status bits are read-only.
- GLOBAL write: bit c = 1 forces a commit of channel c at the same edge. Bits >= CHANNELS are ignored. Reads return 0.
- Reads: offsets 0..0xE return the shadow value. Status, GLOBAL and KEY reads as defined above. Unmapped reads return 0x00.
- Unmapped writes are ignored; o_write_error stays 0 for them.
- Simultaneous write and commit to the same channel:
  - Active takes the pre-write shadow contents.
  - The new byte stays in shadow and pending stays 1.
- Simultaneous updated-set and W1C clear: set wins.

## Timing
- Reset values: all shadow, active, status, lock and sequence state are 0. o_active_regs = 0, o_write_error = 0.
- Writes take effect at the i_clk rising edge where i_write_en = 1.
- o_data is combinational and shows new data from the cycle after the write.
- Commit is triggered at the edge where i_period_end[c] = 1. o_active_regs reflects the committed values from the next cycle; latency is 1 edge.
- Reset mid-operation clears everything asynchronously, including pending shadow data.

## Configuration
- PWM_REGFILE_LOCK_EN defined:
  - KEY register is mapped. Writing 0xC3 sets lock.
  - While locked, every write except to KEY is ignored and pulses o_write_error for one cycle. This includes GLOBAL and status writes.
  - Unlock requires a KEY write of 0x3C, then the next write transaction being KEY 0xA5. Any other intervening write aborts the sequence.
  - A KEY read returns {7'b0, lock}.
- Undefined: KEY is unmapped, lock is never set, and o_write_error is tied 0.

## Structure
- Package pwm_regfile_pkg holds:
  - Offset constants: OFS_CTRL .. OFS_B_DEADBAND, OFS_STATUS
  - CHANNEL_STRIDE = 16, REGS_PER_CHANNEL = 15
  - SHDW_BIT = 7
  - KEY_LOCK = 8'hC3, KEY_UNLOCK1 = 8'h3C, KEY_UNLOCK2 = 8'hA5
- Sub-module pwm_channel_regbank, one per channel via generate: holds shadow/active/pending/updated and its commit logic.
- Top level holds address decode, read mux, GLOBAL and lock FSM (states UNLOCKED, LOCKED, UNLOCK_ARMED).

## Test plan
- Reset, then write 0x12 to 0x01 with SHDW=0 -> active period msb of ch0 = 0x12 next cycle; status reads 0x00.
- Write 0x80 to 0x10, then 0x34 to 0x15 -> ch1 active compa lsb stays 0 and status 0x1F reads 0x01. After i_period_end[1] pulse: active = 0x34 and status = 0x02. Write 0x02 to 0x1F -> status = 0x00.
- ch2 with SHDW=1: write 0x55 to 0x22 in the same cycle as i_period_end[2] -> active stays at old value and pending = 1. Next period_end -> active = 0x55.
- SHDW=1 on ch0 and ch2 with pending writes: write 0x05 to GLOBAL (0x30) -> both channels commit at that edge; ch1 unaffected.
- Read 0x3F -> 0x00; write to 0x3F -> no state change.
- With PWM_REGFILE_LOCK_EN:
  - KEY 0xC3, then write 0x01 to 0x01 -> ignored, o_write_error pulses once.
  - KEY 0x3C, write to 0x05, KEY 0xA5 -> still locked.
  - KEY 0x3C, then KEY 0xA5 -> unlocked; KEY reads 0x00.

Source files
------------

// File: rtl/pwm_regfile_pkg.sv
// Shared constants and types for the PWM shadow register file.
package pwm_regfile_pkg;

  // Byte offsets inside a 16-byte channel window
  localparam logic [3:0] OFS_CTRL       = 4'h0;
  localparam logic [3:0] OFS_PERIOD_MSB = 4'h1;
  localparam logic [3:0] OFS_PERIOD_LSB = 4'h2;
  localparam logic [3:0] OFS_A_ACTION   = 4'h3;
  localparam logic [3:0] OFS_A_COMPA_MSB = 4'h4;
  localparam logic [3:0] OFS_A_COMPA_LSB = 4'h5;
  localparam logic [3:0] OFS_A_COMPB_MSB = 4'h6;
  localparam logic [3:0] OFS_A_COMPB_LSB = 4'h7;
  localparam logic [3:0] OFS_A_DEADBAND = 4'h8;
  localparam logic [3:0] OFS_B_ACTION   = 4'h9;
  localparam logic [3:0] OFS_B_COMPA_MSB = 4'hA;
  localparam logic [3:0] OFS_B_COMPA_LSB = 4'hB;
  localparam logic [3:0] OFS_B_COMPB_MSB = 4'hC;
  localparam logic [3:0] OFS_B_COMPB_LSB = 4'hD;
  localparam logic [3:0] OFS_B_DEADBAND = 4'hE;
  localparam logic [3:0] OFS_STATUS     = 4'hF;

  localparam int CHANNEL_STRIDE   = 16;
  localparam int REGS_PER_CHANNEL = 15;
  localparam int SHDW_BIT         = 7;

  // Key values for the write-lock sequence
  localparam logic [7:0] KEY_LOCK    = 8'hC3;
  localparam logic [7:0] KEY_UNLOCK1 = 8'h3C;
  localparam logic [7:0] KEY_UNLOCK2 = 8'hA5;

  typedef enum logic [1:0] {
    UNLOCKED     = 2'd0,
    LOCKED       = 2'd1,
    UNLOCK_ARMED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/pwm_channel_regbank.sv
// One channel's shadow/active register pair with pending/updated status
// and period-boundary commit.
module pwm_channel_regbank
  import pwm_regfile_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            wr_en,
  input  logic [3:0]                      wr_offset,
  input  logic [7:0]                      wr_data,
  input  logic                            commit,
  input  logic [3:0]                      rd_offset,
  output logic [7:0]                      rd_data,
  output logic [REGS_PER_CHANNEL*8-1:0]   active_regs
);

  logic [7:0] shadow_regs [REGS_PER_CHANNEL];
  logic [7:0] active_q    [REGS_PER_CHANNEL];
  logic       pending;
  logic       updated;

  logic shdw;
  logic reg_write;
  logic status_write;
  logic shadowed_write;

  assign shdw           = active_q[OFS_CTRL][SHDW_BIT];
  assign reg_write      = wr_en && (wr_offset != OFS_STATUS);
  assign status_write   = wr_en && (wr_offset == OFS_STATUS);
  // Control is never held back; everything else waits for commit when SHDW=1
  assign shadowed_write = reg_write && (wr_offset != OFS_CTRL) && shdw;

  // Register storage: commit copies shadow first, a direct write overrides it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < REGS_PER_CHANNEL; k++) begin
        shadow_regs[k] <= 8'h00;
        active_q[k]    <= 8'h00;
      end
    end else begin
      // Commit uses the pre-write shadow, so a same-edge write stays pending
      if (commit) begin
        for (int k = 1; k < REGS_PER_CHANNEL; k++) begin
          active_q[k] <= shadow_regs[k];
        end
      end
      if (reg_write) begin
        shadow_regs[wr_offset] <= wr_data;
        if (!shadowed_write) begin
          active_q[wr_offset] <= wr_data;
        end
      end
    end
  end

  // Status flags: a new shadowed write re-arms pending; updated set beats W1C clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pending <= 1'b0;
      updated <= 1'b0;
    end else begin
      if (commit) begin
        pending <= 1'b0;
      end
      if (shadowed_write) begin
        pending <= 1'b1;
      end
      if (status_write && wr_data[1]) begin
        updated <= 1'b0;
      end
      if (commit && pending) begin
        updated <= 1'b1;
      end
    end
  end

  // Host read view: shadow contents, or the status byte at offset 0xF
  always_comb begin
    rd_data = 8'h00;
    if (rd_offset == OFS_STATUS) begin
      rd_data = {6'b0, updated, pending};
    end else begin
      rd_data = shadow_regs[rd_offset];
    end
  end

  generate
    for (genvar gi = 0; gi < REGS_PER_CHANNEL; gi++) begin : g_active_out
      assign active_regs[gi*8 +: 8] = active_q[gi];
    end
  endgenerate

endmodule

// File: rtl/pwm_shadow_register_file.sv
// Double-buffered PWM configuration register file: address decode, read mux,
// GLOBAL forced commit and optional write-lock.
// Optional feature macro: PWM_REGFILE_LOCK_EN (maps KEY register and lock FSM).
module pwm_shadow_register_file
  import pwm_regfile_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_write_en,
  input  logic [ADDRESS_WIDTH-1:0]          i_address,
  input  logic [7:0]                        i_data,
  output logic [7:0]                        o_data,
  input  logic [CHANNELS-1:0]               i_period_end,
  output logic [CHANNELS*15*8-1:0]          o_active_regs,
  output logic                              o_write_error
);

  localparam logic [ADDRESS_WIDTH-1:0] GLOBAL_ADDR =
    ADDRESS_WIDTH'(CHANNELS * CHANNEL_STRIDE);

  logic                     lock;
  logic                     write_ok;
  logic                     in_channel;
  logic [ADDRESS_WIDTH-5:0] chan_sel;
  logic [3:0]               offset;
  logic [CHANNELS-1:0]      force_commit;
  logic [CHANNELS-1:0]      commit;
  logic [7:0]               chan_rd [CHANNELS];

  assign in_channel = (i_address < GLOBAL_ADDR);
  assign chan_sel   = i_address[ADDRESS_WIDTH-1:4];
  assign offset     = i_address[3:0];
  assign write_ok   = i_write_en && !lock;

  // GLOBAL bits above CHANNELS fall off the slice and are ignored
  assign force_commit = (write_ok && (i_address == GLOBAL_ADDR)) ?
                        i_data[CHANNELS-1:0] : '0;
  assign commit       = i_period_end | force_commit;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      pwm_channel_regbank u_bank (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .wr_en       (write_ok && in_channel &&
                      (chan_sel == (ADDRESS_WIDTH-4)'(gi))),
        .wr_offset   (offset),
        .wr_data     (i_data),
        .commit      (commit[gi]),
        .rd_offset   (offset),
        .rd_data     (chan_rd[gi]),
        .active_regs (o_active_regs[gi*REGS_PER_CHANNEL*8 +: REGS_PER_CHANNEL*8])
      );
    end
  endgenerate

`ifdef PWM_REGFILE_LOCK_EN
  localparam logic [ADDRESS_WIDTH-1:0] KEY_ADDR = GLOBAL_ADDR + 1'b1;

  lock_state_t lock_state;
  lock_state_t lock_state_next;
  logic        key_write;
  logic        mapped_write;
  logic        error_next;

  assign key_write    = i_write_en && (i_address == KEY_ADDR);
  assign mapped_write = i_write_en && (in_channel || (i_address == GLOBAL_ADDR));
  assign lock         = (lock_state != UNLOCKED);

  // Lock state register and registered rejection pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lock_state    <= UNLOCKED;
      o_write_error <= 1'b0;
    end else begin
      lock_state    <= lock_state_next;
      o_write_error <= error_next;
    end
  end

  // Lock sequencing: C3 locks; 3C then immediately A5 unlocks
  always_comb begin
    lock_state_next = lock_state;
    error_next      = 1'b0;
    case (lock_state)
      UNLOCKED: begin
        if (key_write && (i_data == KEY_LOCK)) begin
          lock_state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (key_write && (i_data == KEY_UNLOCK1)) begin
          lock_state_next = UNLOCK_ARMED;
        end
        // Unmapped writes are silently dropped, never flagged
        error_next = mapped_write;
      end
      UNLOCK_ARMED: begin
        if (i_write_en) begin
          if (key_write && (i_data == KEY_UNLOCK2)) begin
            lock_state_next = UNLOCKED;
          end else begin
            lock_state_next = LOCKED;
          end
        end
        error_next = mapped_write;
      end
      default: begin
        lock_state_next = LOCKED;
      end
    endcase
  end
`else
  assign lock          = 1'b0;
  assign o_write_error = 1'b0;
`endif

  // Combinational read mux; GLOBAL and unmapped addresses read zero
  always_comb begin
    o_data = 8'h00;
    if (in_channel) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (chan_sel == (ADDRESS_WIDTH-4)'(c)) begin
          o_data = chan_rd[c];
        end
      end
    end
`ifdef PWM_REGFILE_LOCK_EN
    else if (i_address == KEY_ADDR) begin
      o_data = {7'b0, lock};
    end
`endif
  end

endmodule
